// File: rtl/fp_div_arbiter.sv
// Round-robin front end that time-shares one external combinational FP divider
// between NUM_REQ requesters. Operands are held for DIV_CYCLES cycles, and the
// result is then returned through a valid/ready response register.
module fp_div_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DIV_CYCLES = 4,
  parameter int TAG_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*64-1:0]        req_operand_a,
  input  logic [NUM_REQ*64-1:0]        req_operand_b,
  input  logic [NUM_REQ-1:0]           req_is_double,
  input  logic [NUM_REQ*3-1:0]         req_rounding_mode,
  input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
  output logic [63:0]                  div_operand_a,
  output logic [63:0]                  div_operand_b,
  output logic                         div_is_double,
  output logic [2:0]                   div_rounding_mode,
  input  logic [63:0]                  div_result,
  input  logic [3:0]                   div_flags,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic [63:0]                  rsp_result,
  output logic [3:0]                   rsp_flags
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic               is_dp_q, is_dp_d;
  logic [2:0]         rm_q, rm_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [63:0]        result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  logic [ID_W-1:0]    grant;
  logic               grant_vld;

  // (base + off) modulo NUM_REQ without a divider; off is always < NUM_REQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[rr_index(rr_ptr_q, i)]) begin
        grant     = rr_index(rr_ptr_q, i);
        grant_vld = 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    is_dp_d     = is_dp_q;
    rm_d        = rm_q;
    id_d        = id_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    req_ready   = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant] = 1'b1;
          op_a_d   = req_operand_a[64*int'(grant) +: 64];
          op_b_d   = req_operand_b[64*int'(grant) +: 64];
          is_dp_d  = req_is_double[grant];
          rm_d     = req_rounding_mode[3*int'(grant) +: 3];
          id_d     = grant;
          tag_d    = req_tag[TAG_W*int'(grant) +: TAG_W];
          rr_ptr_d = rr_index(grant, 1);
          cnt_d    = CNT_W'(DIV_CYCLES - 1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d    = div_result;
          flags_d     = div_flags;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // A new request is not taken in the handshake cycle; IDLE follows first.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      is_dp_q     <= 1'b0;
      rm_q        <= '0;
      id_q        <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      is_dp_q     <= is_dp_d;
      rm_q        <= rm_d;
      id_q        <= id_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign div_operand_a     = op_a_q;
  assign div_operand_b     = op_b_q;
  assign div_is_double     = is_dp_q;
  assign div_rounding_mode = rm_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_id            = id_q;
  assign rsp_tag           = tag_q;
  assign rsp_result        = result_q;
  assign rsp_flags         = flags_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Scoreboard bench for fp_div_arbiter: a stand-in divider, a transaction-level
// arbitration/timing model, and a monitor that checks every presented response.
module tb_fp_div_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DIV_CYCLES = 4;
  localparam int TAG_W      = 4;
  localparam int ID_W       = $clog2(NUM_REQ);

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*64-1:0]      req_operand_a;
  logic [NUM_REQ*64-1:0]      req_operand_b;
  logic [NUM_REQ-1:0]         req_is_double;
  logic [NUM_REQ*3-1:0]       req_rounding_mode;
  logic [NUM_REQ*TAG_W-1:0]   req_tag;
  logic [63:0]                div_operand_a, div_operand_b;
  logic                       div_is_double;
  logic [2:0]                 div_rounding_mode;
  logic [63:0]                div_result;
  logic [3:0]                 div_flags;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [TAG_W-1:0]           rsp_tag;
  logic [63:0]                rsp_result;
  logic [3:0]                 rsp_flags;

  fp_div_arbiter #(.NUM_REQ(NUM_REQ), .DIV_CYCLES(DIV_CYCLES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .req_is_double(req_is_double), .req_rounding_mode(req_rounding_mode),
    .req_tag(req_tag),
    .div_operand_a(div_operand_a), .div_operand_b(div_operand_b),
    .div_is_double(div_is_double), .div_rounding_mode(div_rounding_mode),
    .div_result(div_result), .div_flags(div_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Stand-in divider: exact answers for the known vectors, a keyed mix otherwise
  // so that any mis-routed operand, precision or rounding mode changes the result.
  function automatic logic [67:0] div_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic dp, input logic [2:0] rm);
    if (dp && a == 64'h4018000000000000 && b == 64'h4000000000000000 && rm == 3'b000)
      return {4'b0000, 64'h4008000000000000};
    if (!dp && a[31:0] == 32'h3F800000 && b[31:0] == 32'h0)
      return {4'b0100, 32'h0, 32'h7F800000};
    if (dp && a == 64'h3FF0000000000000 && b == 64'h4008000000000000 && rm == 3'b001)
      return {4'b0001, 64'h3FD5555555555555};
    if (dp && a == 64'h3FF0000000000000 && b == 64'h4008000000000000 && rm == 3'b011)
      return {4'b0001, 64'h3FD5555555555556};
    return {a[3:0] ^ b[7:4] ^ {rm, dp}, a ^ {b[31:0], b[63:32]} ^ {60'b0, rm, dp}};
  endfunction

  always_comb {div_flags, div_result} = div_model(div_operand_a, div_operand_b,
                                                  div_is_double, div_rounding_mode);

  typedef struct {
    int               id;
    logic [TAG_W-1:0] tag;
    logic [63:0]      result;
    logic [3:0]       flags;
    int               due;
    bit               seen;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   period   = 0;
  int   rr       = 0;
  bit   outstanding = 1'b0;
  int   rsp_due  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (period %0d)", name, act, exp, period);
    end
  endtask

  // Arbitration/timing model for the current cycle: one op in flight at a time,
  // response visible DIV_CYCLES+1 cycles after the accept cycle, free again the
  // cycle after the consumer takes it.
  task automatic model_check();
    int winner;
    exp_t e;
    if (!rst_n) begin
      check("req_ready_in_reset", 64'(req_ready), 64'(0));
      return;
    end
    if (!outstanding) begin
      winner = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
        int j;
        j = (rr + i) % NUM_REQ;
        if (winner < 0 && req_valid[j]) winner = j;
      end
      check("req_ready_idle", 64'(req_ready), (winner >= 0) ? (64'd1 << winner) : 64'd0);
      if (winner >= 0) begin
        {e.flags, e.result} = div_model(req_operand_a[64*winner +: 64], req_operand_b[64*winner +: 64],
                                        req_is_double[winner], req_rounding_mode[3*winner +: 3]);
        e.id   = winner;
        e.tag  = req_tag[TAG_W*winner +: TAG_W];
        e.due  = period + 1 + DIV_CYCLES;
        e.seen = 1'b0;
        sb.push_back(e);
        grant_log.push_back(winner);
        rr          = (winner + 1) % NUM_REQ;
        outstanding = 1'b1;
        rsp_due     = e.due;
      end
    end else begin
      check("req_ready_busy", 64'(req_ready), 64'(0));
      if (period >= rsp_due && rsp_ready) outstanding = 1'b0;
    end
  endtask

  // Inputs are set just after a rising edge; this checks and advances one cycle.
  task automatic run_cycle();
    #1;
    model_check();
    @(posedge clk);
    #1;
    period++;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic dp, input logic [2:0] rm, input logic [TAG_W-1:0] tag);
    req_operand_a[64*i +: 64]        = a;
    req_operand_b[64*i +: 64]        = b;
    req_is_double[i]                 = dp;
    req_rounding_mode[3*i +: 3]      = rm;
    req_tag[TAG_W*i +: TAG_W]        = tag;
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
              3'($urandom_range(0, 3)), TAG_W'($urandom));
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_div_a", div_operand_a, 64'(0));
    check("rst_div_b", div_operand_b, 64'(0));
    check("rst_div_mode", 64'({div_is_double, div_rounding_mode}), 64'(0));
    check("rst_rsp_id_tag", 64'({rsp_id, rsp_tag}), 64'(0));
    check("rst_rsp_result", rsp_result, 64'(0));
    check("rst_rsp_flags", 64'(rsp_flags), 64'(0));
    sb.delete();
    outstanding = 1'b0;
    rr          = 0;
    repeat (2) run_cycle();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n         = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((outstanding || sb.size() != 0) && n < max_cyc) begin
      run_cycle();
      n++;
    end
    check("drain_complete", 64'(outstanding || sb.size() != 0), 64'(0));
  endtask

  // Monitor: compares every presented response with the scoreboard head and
  // retires it when the consumer accepts.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_spurious", 64'(rsp_valid), 64'(0));
        end else begin
          e = sb[0];
          if (!e.seen) begin
            check("rsp_latency", 64'(period), 64'(e.due));
            sb[0].seen = 1'b1;
          end
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          check("rsp_result", rsp_result, e.result);
          check("rsp_flags", 64'(rsp_flags), 64'(e.flags));
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int start;
    int n;
    int exp_g[5] = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_operand_a = '0;
    req_operand_b = '0;
    req_is_double = '0;
    req_rounding_mode = '0;
    req_tag = '0;
    @(posedge clk);
    #1;
    do_reset();

    // 3.0 = 6.0 / 2.0 in double precision from requester 0.
    set_req(0, 64'h4018000000000000, 64'h4000000000000000, 1'b1, 3'b000, 4'h5);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    run_cycle();
    req_valid = '0;
    set_req(0, 64'h0, 64'h0, 1'b0, 3'b000, 4'h0);
    check("t1_div_operand_a", div_operand_a, 64'h4018000000000000);
    check("t1_div_is_double", 64'(div_is_double), 64'(1));
    drain(20);

    // All four valid from reset: round-robin order 0,1,2,3,0.
    do_reset();
    grant_log.delete();
    req_valid = '1;
    rsp_ready = 1'b1;
    n = 0;
    while (grant_log.size() < 5 && n < 60) begin
      rand_reqs();
      run_cycle();
      n++;
    end
    check("t2_grant_count", 64'(grant_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'(exp_g[i]));
    drain(20);

    // Consumer stalls for 10 cycles in DONE while everyone keeps requesting.
    rand_reqs();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    run_cycle();
    req_valid = '1;
    start = grant_log.size();
    repeat (DIV_CYCLES + 10) begin
      rand_reqs();
      run_cycle();
    end
    check("t3_no_grant_while_stalled", 64'(grant_log.size()), 64'(start));
    rsp_ready = 1'b1;
    run_cycle();
    run_cycle();
    check("t3_next_grant", 64'(grant_log[grant_log.size()-1]), 64'(2));
    drain(20);

    // 1.0 / 3.0 with RTZ and then RUP from requester 0.
    set_req(0, 64'h3FF0000000000000, 64'h4008000000000000, 1'b1, 3'b001, 4'hA);
    req_valid = 4'b0001;
    run_cycle();
    drain(20);
    set_req(0, 64'h3FF0000000000000, 64'h4008000000000000, 1'b1, 3'b011, 4'hB);
    req_valid = 4'b0001;
    run_cycle();
    drain(20);

    // Single-precision 1.0 / 0.0 from requester 2; the pointer then points at 3.
    set_req(2, 64'h000000003F800000, 64'h0, 1'b0, 3'b000, 4'h7);
    req_valid = 4'b0100;
    run_cycle();
    drain(20);
    req_valid = '1;
    run_cycle();
    check("t4_grant_after_req2", 64'(grant_log[grant_log.size()-1]), 64'(3));
    drain(20);

    // Reset while busy: the op is dropped and the pointer returns to 0.
    rand_reqs();
    req_valid = 4'b0010;
    run_cycle();
    req_valid = '0;
    run_cycle();
    run_cycle();
    do_reset();
    rsp_ready = 1'b1;
    repeat (DIV_CYCLES + 4) begin
      run_cycle();
      check("t5_no_stale_rsp", 64'(rsp_valid), 64'(0));
    end
    req_valid = '1;
    run_cycle();
    check("t5_grant_after_reset", 64'(grant_log[grant_log.size()-1]), 64'(0));
    drain(20);

    // Random traffic, dropping requests and stalling the consumer.
    repeat (400) begin
      rand_reqs();
      req_valid = NUM_REQ'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      run_cycle();
    end
    drain(50);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
